pipe_add: RTL and testbench
===========================

Name: pipe_add

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor.
- Each pipeline stage resolves one WIDTH/STAGES-bit slice of the carry chain with a registered carry.
- Uses a valid/ready handshake on input and output, with full backpressure.
- Serves the ALU/address-generation datapath wherever a wide add must be split across cycles for timing.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of register stages (1..WIDTH); slice width SW = WIDTH/STAGES.

Ports:
- I_CLK  in  1  clock, rising edge.
- I_RST  in  1  asynchronous, active-high reset.
- I_VALID  in  1  input operands valid.
- O_READY  out  1  block can accept an input this cycle.
- I_A  in  WIDTH  operand A.
- I_B  in  WIDTH  operand B.
- I_CI  in  1  carry in (borrow in when subtracting).
- I_SUB  in  1  0 = add, 1 = subtract.
- O_VALID  out  1  result valid.
- I_READY  in  1  downstream accepts the result.
- O_SUM  out  WIDTH  result.
- O_CO  out  1  carry out of MSB (subtract: 1 = no borrow).
- O_OVF  out  1  signed overflow.
- O_ZERO  out  1  O_SUM == 0.

Behaviour:
- Arithmetic: result = A + (B ^ {WIDTH{SUB}}) + (CI ^ SUB), computed modulo 2^WIDTH.
  - SUB=1, CI=0 gives A-B.
  - SUB=1, CI=1 gives A-B-1.
- O_CO is the carry out of bit WIDTH-1.
- O_OVF = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Stage k (0..STAGES-1) adds slice k (bits k*SW+SW-1 .. k*SW) using the carry registered by stage k-1. Stage 0 uses CI^SUB.
- Stage k registers:
  - its slice sum;
  - all lower result slices already computed;
  - the untouched upper operand slices (B already conditioned by SUB);
  - the slice carry-out;
  - for the top stage only, the carry into the MSB.
- Valid/ready pipeline:
  - Each stage has a valid bit v[k].
  - Stage k loads when its upstream has data and (!v[k] or stage k+1 loads); for the last stage, "stage k+1 loads" means I_READY.
  - O_READY = !v[0] | load-enable of stage 1 (combinational through I_READY). No combinational path from I_VALID to O_READY.
  - Transfer occurs on I_VALID & O_READY; output transfer occurs on O_VALID & I_READY.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input acceptance to O_VALID, when unstalled.
  - Throughput is 1 result/cycle when I_READY=1.
- O_VALID = v[STAGES-1].
  - O_SUM/O_CO/O_OVF/O_ZERO hold stable while O_VALID & !I_READY.
  - Their values are don't-care while O_VALID=0.
- Stall: I_READY=0 freezes a full stage and compresses bubbles upstream of it; no data is lost or duplicated; order is preserved.
- Simultaneous events: accepting a new input while the output is consumed in the same cycle keeps occupancy constant.
- Reset, at assertion, asynchronously and including mid-operation:
  - all v[k] = 0, so O_VALID = 0 and in-flight results are discarded;
  - all data registers = 0, so O_SUM = 0, O_CO = 0, O_OVF = 0, O_ZERO = 0.
  - O_READY = 1 from the first cycle after reset is released.
- STAGES=1: a single registered full-width add with latency 1.
- STAGES=WIDTH: a bit-serial skewed ripple.
- Parameter check: elaboration-time error if WIDTH % STAGES != 0 or STAGES < 1.

Decomposition:
- Shared package (datapath pkg) holds:
  - the slice-width function SW = WIDTH/STAGES;
  - the opcode constants ADD=1'b0, SUB=1'b1.
- One sub-module, add_slice:
  - purely combinational SW-bit carry-ripple slice, built from the team's 1-bit full adder;
  - outputs: slice sum, carry out, and the carry into its MSB.
  - Instantiated STAGES times with a generate loop; pipe_add owns all registers and handshake.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- Basic add: A=0x0000_0001, B=0x0000_0002, CI=0, SUB=0, I_READY=1 -> O_VALID exactly 4 cycles after accept; SUM=0x0000_0003, CO=0, OVF=0, ZERO=0.
- Full carry ripple across all slices: A=0xFFFF_FFFF, B=0x0000_0001 -> SUM=0, CO=1, ZERO=1, OVF=0. Then A=0x7FFF_FFFF, B=1 -> SUM=0x8000_0000, OVF=1, CO=0.
- Subtract/borrow:
  - SUB=1, A=5, B=5, CI=0 -> SUM=0, CO=1, ZERO=1.
  - A=3, B=5 -> SUM=0xFFFF_FFFE, CO=0.
  - A=5, B=3, CI=1 -> SUM=1.
- Backpressure: stream 10 back-to-back random ops; hold I_READY=0 for cycles 6-11 -> O_READY drops once all 4 stages are full; every result matches the reference model in order, with no drops or duplicates; throughput returns to 1/cycle after release.
- Reset mid-operation: 3 ops in flight; assert I_RST asynchronously between clock edges -> O_VALID=0 and all outputs 0 immediately; after release, O_READY=1 and no stale result ever appears.
- Parameter sweep (STAGES=1, 2, 32; WIDTH=8, 64): 1000 random ops each with random I_READY -> all results correct; latency equals STAGES.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// Shared datapath definitions for the pipelined adder: opcodes, slice sizing
// and the 1-bit full adder the carry-ripple slices are built from.
package pipe_add_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int unsigned slice_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/pipe_add_add_slice.sv
// Combinational SW-bit carry-ripple slice; also exposes the carry into its
// MSB so the top slice can derive signed overflow.
module add_slice
    import pipe_add_pkg::*;
#(
    parameter int unsigned SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co,
    output logic          cmsb
);

    logic [SW:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < SW; i++) begin
            {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
        end
        co   = c[SW];
        cmsb = c[SW-1];
    end

endmodule

// File: rtl/pipe_add.sv
// Pipelined WIDTH-bit adder/subtractor: each stage resolves one SW-bit slice
// of the carry chain, with valid/ready handshaking and full backpressure.
module pipe_add
    import pipe_add_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             I_VALID,
    output logic             O_READY,
    input  logic [WIDTH-1:0] I_A,
    input  logic [WIDTH-1:0] I_B,
    input  logic             I_CI,
    input  logic             I_SUB,
    output logic             O_VALID,
    input  logic             I_READY,
    output logic [WIDTH-1:0] O_SUM,
    output logic             O_CO,
    output logic             O_OVF,
    output logic             O_ZERO
);

    localparam int unsigned SW = slice_width(WIDTH, STAGES);
    localparam int unsigned YN = (STAGES > 1) ? STAGES - 1 : 1;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipe_add: WIDTH must be a non-zero multiple of STAGES");
    end

    logic [STAGES-1:0] v_q, ld, accept, drain, c_q, c_in, co_sl, cm_sl;
    logic              cmsb_q, zero_q;
    logic [WIDTH-1:0]  x_q  [STAGES];
    logic [WIDTH-1:0]  x_in [STAGES];
    logic [WIDTH-1:0]  x_nx [STAGES];
    logic [WIDTH-1:0]  y_in [STAGES];
    logic [WIDTH-1:0]  y_q  [YN];
    logic [WIDTH-1:0]  y_nx [YN];
    logic [SW-1:0]     s_sl [STAGES];

    // A stage can take data iff downstream drains or some stage at or after it
    // is empty; that closed form avoids a ripple through the load enables.
    always_comb begin
        logic        acc;
        int unsigned k;
        accept = '0;
        drain  = '0;
        ld     = '0;
        acc    = I_READY;
        k      = 0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            k         = STAGES - 1 - i;
            drain[k]  = acc;
            acc       = acc | ~v_q[k];
            accept[k] = acc;
        end
        ld[0] = I_VALID & accept[0];
        for (int unsigned i = 1; i < STAGES; i++) begin
            ld[i] = v_q[i-1] & accept[i];
        end
    end

    // x carries {finished sum slices, remaining A slices}, rotated right by SW
    // per stage so the next A slice always sits in the low bits.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign x_in[k] = I_A;
            assign y_in[k] = I_B ^ {WIDTH{I_SUB == OP_SUB}};
            assign c_in[k] = I_CI ^ I_SUB;
        end else begin : g_next
            assign x_in[k] = x_q[k-1];
            assign y_in[k] = y_q[k-1];
            assign c_in[k] = c_q[k-1];
        end

        add_slice #(.SW(SW)) u_slice (
            .a    (x_in[k][SW-1:0]),
            .b    (y_in[k][SW-1:0]),
            .ci   (c_in[k]),
            .s    (s_sl[k]),
            .co   (co_sl[k]),
            .cmsb (cm_sl[k])
        );

        if (SW == WIDTH) begin : g_full
            assign x_nx[k] = s_sl[k];
        end else begin : g_rot
            assign x_nx[k] = {s_sl[k], x_in[k][WIDTH-1:SW]};
        end

        if (k < STAGES - 1) begin : g_fwd
            assign y_nx[k] = {{SW{1'b0}}, y_in[k][WIDTH-1:SW]};
        end
    end

    if (STAGES == 1) begin : g_no_fwd
        assign y_nx[0] = '0;
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            v_q    <= '0;
            c_q    <= '0;
            cmsb_q <= 1'b0;
            zero_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) x_q[k] <= '0;
            for (int unsigned k = 0; k < YN; k++)     y_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= ld[k] | (v_q[k] & ~drain[k]);
                if (ld[k]) begin
                    x_q[k] <= x_nx[k];
                    c_q[k] <= co_sl[k];
                end
            end
            for (int unsigned k = 0; k + 1 < STAGES; k++) begin
                if (ld[k]) y_q[k] <= y_nx[k];
            end
            if (ld[STAGES-1]) begin
                cmsb_q <= cm_sl[STAGES-1];
                zero_q <= ~|x_nx[STAGES-1];
            end
        end
    end

    assign O_READY = accept[0];
    assign O_VALID = v_q[STAGES-1];
    assign O_SUM   = x_q[STAGES-1];
    assign O_CO    = c_q[STAGES-1];
    assign O_OVF   = cmsb_q ^ c_q[STAGES-1];
    assign O_ZERO  = zero_q;

endmodule

// File: tb/tb_pipe_add.sv
// Directed and model-checked bench for pipe_add: default 32/4 instance plus
// a set of alternative WIDTH/STAGES instances for the parameter sweep.
module tb_pipe_add;

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ovf;
        logic        zero;
    } res_t;

    localparam int NI = 4;
    localparam int unsigned SWP_W [NI] = '{8, 64, 32, 8};
    localparam int unsigned SWP_S [NI] = '{1, 2, 32, 8};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0, rdy = 1'b1, ci = 1'b0, sub = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        o_ready, o_valid, co, ovf, zero;
    logic [31:0] sum;

    logic [NI-1:0] sw_valid = '0;
    logic [63:0]   sw_a = '0, sw_b = '0;
    logic          sw_ci = 1'b0, sw_sub = 1'b0, sw_rdy = 1'b1;
    logic [NI-1:0] sw_ordy, sw_ov, sw_co, sw_ovf, sw_zero;
    logic [7:0]    s0, s3;
    logic [63:0]   s1;
    logic [31:0]   s2;
    logic [63:0]   sw_sum [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_add #(.WIDTH(32), .STAGES(4)) dut (
        .I_CLK(clk), .I_RST(rst), .I_VALID(valid), .O_READY(o_ready),
        .I_A(a), .I_B(b), .I_CI(ci), .I_SUB(sub), .O_VALID(o_valid),
        .I_READY(rdy), .O_SUM(sum), .O_CO(co), .O_OVF(ovf), .O_ZERO(zero)
    );

    pipe_add #(.WIDTH(8), .STAGES(1)) u_w8_s1 (
        .I_CLK(clk), .I_RST(rst), .I_VALID(sw_valid[0]), .O_READY(sw_ordy[0]),
        .I_A(sw_a[7:0]), .I_B(sw_b[7:0]), .I_CI(sw_ci), .I_SUB(sw_sub), .O_VALID(sw_ov[0]),
        .I_READY(sw_rdy), .O_SUM(s0), .O_CO(sw_co[0]), .O_OVF(sw_ovf[0]), .O_ZERO(sw_zero[0])
    );

    pipe_add #(.WIDTH(64), .STAGES(2)) u_w64_s2 (
        .I_CLK(clk), .I_RST(rst), .I_VALID(sw_valid[1]), .O_READY(sw_ordy[1]),
        .I_A(sw_a), .I_B(sw_b), .I_CI(sw_ci), .I_SUB(sw_sub), .O_VALID(sw_ov[1]),
        .I_READY(sw_rdy), .O_SUM(s1), .O_CO(sw_co[1]), .O_OVF(sw_ovf[1]), .O_ZERO(sw_zero[1])
    );

    pipe_add #(.WIDTH(32), .STAGES(32)) u_w32_s32 (
        .I_CLK(clk), .I_RST(rst), .I_VALID(sw_valid[2]), .O_READY(sw_ordy[2]),
        .I_A(sw_a[31:0]), .I_B(sw_b[31:0]), .I_CI(sw_ci), .I_SUB(sw_sub), .O_VALID(sw_ov[2]),
        .I_READY(sw_rdy), .O_SUM(s2), .O_CO(sw_co[2]), .O_OVF(sw_ovf[2]), .O_ZERO(sw_zero[2])
    );

    pipe_add #(.WIDTH(8), .STAGES(8)) u_w8_s8 (
        .I_CLK(clk), .I_RST(rst), .I_VALID(sw_valid[3]), .O_READY(sw_ordy[3]),
        .I_A(sw_a[7:0]), .I_B(sw_b[7:0]), .I_CI(sw_ci), .I_SUB(sw_sub), .O_VALID(sw_ov[3]),
        .I_READY(sw_rdy), .O_SUM(s3), .O_CO(sw_co[3]), .O_OVF(sw_ovf[3]), .O_ZERO(sw_zero[3])
    );

    always_comb begin
        sw_sum[0] = {56'b0, s0};
        sw_sum[1] = s1;
        sw_sum[2] = {32'b0, s2};
        sw_sum[3] = {56'b0, s3};
    end

    // Reference: overflow from operand/result signs, carry from a wide add.
    function automatic res_t model(input int unsigned w, input logic [63:0] ma,
                                   input logic [63:0] mb, input logic mci, input logic msub);
        logic [64:0] mask, am, bm, full;
        res_t r;
        mask   = (65'd1 << w) - 65'd1;
        am     = {1'b0, ma} & mask;
        bm     = {1'b0, (msub ? ~mb : mb)} & mask;
        full   = am + bm + {64'b0, mci ^ msub};
        r.s    = full[63:0] & mask[63:0];
        r.co   = full[w];
        r.ovf  = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
        r.zero = (r.s == 64'd0);
        return r;
    endfunction

    // Sends one op on an idle pipe with I_READY=1; lat counts edges from the
    // accepting edge to O_VALID, or -1 if it never appears.
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic oci,
                          input logic osub, output logic [31:0] rs, output logic rco,
                          output logic rovf, output logic rz, output int lat);
        bit acc = 0;
        int n;
        rdy = 1'b1;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            a = oa; b = ob; ci = oci; sub = osub; valid = 1'b1;
            #1 acc = o_ready;
            @(posedge clk);
        end
        n = 1;
        @(negedge clk);
        valid = 1'b0;
        while (n <= 20 && !o_valid) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        lat = (acc && o_valid) ? n : -1;
        rs = sum; rco = co; rovf = ovf; rz = zero;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({o_valid, sum, co, ovf, zero} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b sum=%h co=%b ovf=%b zero=%b, expected all 0",
                     o_valid, sum, co, ovf, zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b valid=%b, expected ready=1 valid=0", o_ready, o_valid);
        end
    endtask

    task automatic test_basic();
        logic [31:0] s;
        logic c, v, z;
        int lat;
        run_op(32'h1, 32'h2, 1'b0, 1'b0, s, c, v, z, lat);
        n_tests++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, expected 4", lat);
        end
        n_tests++;
        if ({s, c, v, z} !== {32'h3, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_add: got sum=%h co=%b ovf=%b zero=%b, expected 00000003 0 0 0", s, c, v, z);
        end
    endtask

    task automatic test_carry();
        logic [31:0] s;
        logic c, v, z;
        int lat;
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, s, c, v, z, lat);
        n_tests++;
        if ({s, c, v, z} !== {32'h0, 1'b1, 1'b0, 1'b1} || lat !== 4) begin
            n_fail++;
            $display("FAIL carry_wrap: got sum=%h co=%b ovf=%b zero=%b lat=%0d, expected 00000000 1 0 1 4",
                     s, c, v, z, lat);
        end
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, s, c, v, z, lat);
        n_tests++;
        if ({s, c, v, z} !== {32'h8000_0000, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL carry_ovf: got sum=%h co=%b ovf=%b zero=%b, expected 80000000 0 1 0", s, c, v, z);
        end
    endtask

    task automatic test_subtract();
        logic [31:0] s;
        logic c, v, z;
        int lat;
        run_op(32'd5, 32'd5, 1'b0, 1'b1, s, c, v, z, lat);
        n_tests++;
        if ({s, c, v, z} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_equal: got sum=%h co=%b ovf=%b zero=%b, expected 00000000 1 0 1", s, c, v, z);
        end
        run_op(32'd3, 32'd5, 1'b0, 1'b1, s, c, v, z, lat);
        n_tests++;
        if ({s, c, v, z} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_borrow: got sum=%h co=%b ovf=%b zero=%b, expected fffffffe 0 0 0", s, c, v, z);
        end
        run_op(32'd5, 32'd3, 1'b1, 1'b1, s, c, v, z, lat);
        n_tests++;
        if ({s, c, v, z} !== {32'h1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_borrow_in: got sum=%h co=%b ovf=%b zero=%b, expected 00000001 1 0 0", s, c, v, z);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic        vci [10];
        logic        vsub [10];
        res_t        ex;
        int          sent = 0, recv = 0, cyc = 0;
        bit          saw_block = 0, gap = 0, hold_v = 0;
        logic [34:0] hold_d = '0;
        for (int i = 0; i < 10; i++) begin
            va[i] = $urandom; vb[i] = $urandom;
            vci[i] = 1'($urandom_range(0, 1)); vsub[i] = 1'($urandom_range(0, 1));
        end
        while (recv < 10 && cyc < 60) begin
            @(negedge clk);
            valid = (sent < 10);
            if (sent < 10) begin
                a = va[sent]; b = vb[sent]; ci = vci[sent]; sub = vsub[sent];
            end
            rdy = !(cyc >= 6 && cyc <= 11);
            #1;
            if (!o_ready) saw_block = 1;
            if (hold_v) begin
                n_tests++;
                if ({sum, co, ovf, zero} !== hold_d) begin
                    n_fail++;
                    $display("FAIL bp_hold: got %h, expected %h while stalled", {sum, co, ovf, zero}, hold_d);
                end
            end
            hold_v = o_valid && !rdy;
            hold_d = {sum, co, ovf, zero};
            if (cyc >= 12 && !o_valid) gap = 1;
            if (o_valid && rdy) begin
                ex = model(32, {32'b0, va[recv]}, {32'b0, vb[recv]}, vci[recv], vsub[recv]);
                n_tests++;
                if ({sum, co, ovf, zero} !== {ex.s[31:0], ex.co, ex.ovf, ex.zero}) begin
                    n_fail++;
                    $display("FAIL bp_result[%0d]: got %h %b%b%b, expected %h %b%b%b", recv,
                             sum, co, ovf, zero, ex.s[31:0], ex.co, ex.ovf, ex.zero);
                end
                recv++;
            end
            if (valid && o_ready) sent++;
            cyc++;
        end
        valid = 1'b0;
        rdy   = 1'b1;
        n_tests++;
        if (recv != 10 || sent != 10) begin
            n_fail++;
            $display("FAIL bp_count: got sent=%0d recv=%0d, expected 10 10", sent, recv);
        end
        n_tests++;
        if (!saw_block) begin
            n_fail++;
            $display("FAIL bp_ready_drop: got O_READY never low, expected low while full");
        end
        n_tests++;
        if (gap) begin
            n_fail++;
            $display("FAIL bp_throughput: got a bubble after release, expected 1 result/cycle");
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_duplicate: got O_VALID=%b after drain, expected 0", o_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit stale = 0;
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 32'(i + 10); b = 32'(i * 7); ci = 1'b0; sub = 1'b0; valid = 1'b1;
        end
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #2;
        n_tests++;
        if (o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_inflight: got O_VALID=%b before reset, expected 1", o_valid);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({o_valid, sum, co, ovf, zero} !== 36'd0) begin
            n_fail++;
            $display("FAIL rmid_clear: got valid=%b sum=%h co=%b ovf=%b zero=%b, expected all 0",
                     o_valid, sum, co, ovf, zero);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_ready: got O_READY=%b after release, expected 1", o_ready);
        end
        for (int i = 0; i < 10; i++) begin
            if (o_valid !== 1'b0) stale = 1;
            @(negedge clk);
        end
        n_tests++;
        if (stale) begin
            n_fail++;
            $display("FAIL rmid_stale: got O_VALID=1 after reset, expected no results");
        end
    endtask

    task automatic test_param_sweep();
        res_t        eb [NI][128];
        int          ac [NI][128];
        int unsigned wr [NI];
        int unsigned rd [NI];
        int          cyc = 0;
        bit          done = 0;
        res_t        ex, got;
        for (int i = 0; i < NI; i++) begin
            wr[i] = 0; rd[i] = 0;
        end
        while (!done && cyc < 20000) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) sw_valid[i] = (wr[i] < 1000);
            sw_a   = {$urandom, $urandom};
            sw_b   = {$urandom, $urandom};
            sw_ci  = 1'($urandom_range(0, 1));
            sw_sub = 1'($urandom_range(0, 1));
            sw_rdy = (cyc < 80) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (sw_ov[i] && sw_rdy) begin
                    got = {sw_sum[i], sw_co[i], sw_ovf[i], sw_zero[i]};
                    ex  = eb[i][rd[i] % 128];
                    n_tests++;
                    if (rd[i] == wr[i]) begin
                        n_fail++;
                        $display("FAIL sweep%0d_spurious: got result %h with none pending", i, got.s);
                    end else if (got !== ex) begin
                        n_fail++;
                        $display("FAIL sweep%0d_result[%0d]: got %h %b%b%b, expected %h %b%b%b", i, rd[i],
                                 got.s, got.co, got.ovf, got.zero, ex.s, ex.co, ex.ovf, ex.zero);
                    end
                    if (rd[i] == 0 && wr[i] != 0) begin
                        n_tests++;
                        if (cyc - ac[i][0] != int'(SWP_S[i])) begin
                            n_fail++;
                            $display("FAIL sweep%0d_latency: got %0d, expected %0d", i,
                                     cyc - ac[i][0], SWP_S[i]);
                        end
                    end
                    if (rd[i] != wr[i]) rd[i]++;
                end
                if (sw_valid[i] && sw_ordy[i]) begin
                    eb[i][wr[i] % 128] = model(SWP_W[i], sw_a, sw_b, sw_ci, sw_sub);
                    ac[i][wr[i] % 128] = cyc;
                    wr[i]++;
                end
            end
            done = 1;
            for (int i = 0; i < NI; i++) if (rd[i] < 1000) done = 0;
            cyc++;
        end
        sw_valid = '0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL sweep_timeout: got %0d/%0d/%0d/%0d results, expected 1000 each",
                     rd[0], rd[1], rd[2], rd[3]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_subtract();
        test_backpressure();
        test_reset_mid();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
